grid_stream_sequencer: RTL
==========================

Name: grid_stream_sequencer

Overview:
Sequencer that feeds the grid AXI-Stream input of the KAN data processor. It holds a programmable table of grid points and replays the table once per input sample, with tlast on each sample's final point. It counts result frames leaving the processor, signals batch completion, and aborts on processor error flags. It sits between the host configuration path and the processor's grid input.

Parameters:
DATA_WIDTH, 16, grid point width in bits (matches the processor data/grid width)
MAX_GRID, 16, grid table depth; also the maximum points per sample
ADDR_WIDTH, $clog2(MAX_GRID), table address width
BATCH_WIDTH, 16, sample counter width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
cfg_wr_en  input  1  grid table write strobe
cfg_addr  input  ADDR_WIDTH  grid table write address
cfg_wdata  input  DATA_WIDTH  grid table write data
cfg_grid_len  input  ADDR_WIDTH+1  points per sample; latched on start
cfg_batch  input  BATCH_WIDTH  samples per batch; latched on start
start  input  1  single-cycle start pulse
busy  output  1  high from accepted start until done/abort
done  output  1  one-cycle pulse at batch completion
error  output  1  sticky abort/config error; cleared by next accepted start
m_axis_grid_tdata  output  DATA_WIDTH  grid point
m_axis_grid_tvalid  output  1  grid valid
m_axis_grid_tready  input  1  grid ready
m_axis_grid_tlast  output  1  last point of the current sample
mon_rslt_tvalid  input  1  monitored processor output valid
mon_rslt_tready  input  1  monitored processor output ready
mon_rslt_tlast  input  1  monitored processor output last
err_unalligned_data  input  1  processor alignment error
err_user_flag  input  1  processor user-flag error

Behaviour:
- Reset (rst low, async): state IDLE. busy, done, error, tvalid, tlast are 0. tdata and all counters are 0. Table contents are not reset.
- Table writes are accepted only in IDLE. A write while busy is ignored.
- States: IDLE, STREAM, DRAIN, DONE, ABORT.
- IDLE, on start:
  - Latch cfg_grid_len into L and cfg_batch into B.
  - Clear error and counters.
  - If L > MAX_GRID: go to ABORT (config error).
  - Else if L == 0 or B == 0: go to DONE with no stream traffic.
  - Else: go to STREAM.
- start outside IDLE is ignored.
- STREAM:
  - Output is registered. First tvalid appears the cycle after start, carrying table[0].
  - tvalid stays high and tdata/tlast stay stable until tvalid && tready.
  - After each handshake, the next point is presented in the next cycle with no bubble: table[pt+1], or table[0] for a new sample.
  - tlast = (pt == L-1).
  - On the handshake with tlast: sample count s increments. If s reaches B, tvalid falls in the next cycle and the state goes to DRAIN.
- Result counting: counter r increments on each mon_rslt_tvalid && mon_rslt_tready && mon_rslt_tlast while busy, in any busy state, including during STREAM.
- DRAIN: when r == B, go to DONE.
- Edge case: if the final grid handshake and r reaching B happen in the same cycle, go from STREAM directly to DONE.
- DONE: done pulses high for 1 cycle and busy falls in the same cycle. Next state is IDLE.
- Abort condition: err_unalligned_data or err_user_flag high in STREAM or DRAIN.
  - Go to ABORT next cycle. tvalid drops immediately; the processor self-resets on error, so the AXI hold rule is waived.
  - Error takes priority over a simultaneous final handshake.
- ABORT: error set (sticky), busy falls, no done pulse. Next state is IDLE.
- busy = state is STREAM or DRAIN.
- Counter widths: pt is ADDR_WIDTH+1 bits; s and r are BATCH_WIDTH bits.
- Result frames seen in IDLE are not counted.

Test Plan:
- Write table[0..3] = 0x1000, 0x2000, 0x3000, 0x4000; start with L=4, B=2, tready=1 -> 8 beats: 1000, 2000, 3000, 4000, 1000, 2000, 3000, 4000; tlast on beats 4 and 8. After 2 result tlast handshakes, done pulses once and busy falls.
- Same config with tready toggling 1/0 every cycle -> tdata/tlast held stable while stalled; beat order unchanged; exactly 8 handshakes.
- L=4, B=2; two result tlast frames arrive before grid streaming ends -> DONE the cycle after the last grid handshake (the direct STREAM-to-DONE edge case).
- Start with L=17 (MAX_GRID=16) -> error=1, busy never set, no tvalid. Start with L=0, B=5 -> done pulses, no beats.
- err_user_flag pulse after beat 3 of L=4, B=2 -> tvalid low next cycle; error=1; no done. A new start clears error and stream restarts at table[0].
- rst driven low mid-STREAM -> outputs 0 asynchronously. After release, start with L=2, B=1 streams table[0], table[1] correctly (table retained).

Source files
------------

// File: rtl/grid_stream_sequencer.sv
// Grid-point sequencer for the KAN processor grid stream: replays a programmable
// table once per sample, counts result frames, and reports batch done or abort.
module grid_stream_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_GRID    = 16,
    parameter int ADDR_WIDTH  = $clog2(MAX_GRID),
    parameter int BATCH_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [DATA_WIDTH-1:0]  cfg_wdata,
    input  logic [ADDR_WIDTH:0]    cfg_grid_len,
    input  logic [BATCH_WIDTH-1:0] cfg_batch,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [DATA_WIDTH-1:0]  m_axis_grid_tdata,
    output logic                   m_axis_grid_tvalid,
    input  logic                   m_axis_grid_tready,
    output logic                   m_axis_grid_tlast,
    input  logic                   mon_rslt_tvalid,
    input  logic                   mon_rslt_tready,
    input  logic                   mon_rslt_tlast,
    input  logic                   err_unalligned_data,
    input  logic                   err_user_flag
);

    localparam logic [ADDR_WIDTH:0]    MAX_L = (ADDR_WIDTH+1)'(MAX_GRID);
    localparam logic [ADDR_WIDTH:0]    ONE_L = (ADDR_WIDTH+1)'(1);
    localparam logic [BATCH_WIDTH-1:0] ONE_B = BATCH_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE, S_ABORT} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_WIDTH-1:0]  r_grid [MAX_GRID];
    logic [ADDR_WIDTH:0]    r_len;
    logic [ADDR_WIDTH:0]    r_pt;
    logic [BATCH_WIDTH-1:0] r_batch;
    logic [BATCH_WIDTH-1:0] r_s;
    logic [BATCH_WIDTH-1:0] r_r;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [DATA_WIDTH-1:0]  r_tdata;
    logic                   r_error;

    logic                   w_start;
    logic                   w_cfg_bad;
    logic                   w_cfg_empty;
    logic                   w_busy;
    logic                   w_err_in;
    logic                   w_hs;
    logic                   w_final_hs;
    logic                   w_rslt;
    logic [BATCH_WIDTH-1:0] w_s_inc;
    logic [BATCH_WIDTH-1:0] w_r_next;
    logic [ADDR_WIDTH:0]    w_pt_inc;

    assign w_start     = start && (r_state == S_IDLE);
    assign w_cfg_bad   = cfg_grid_len > MAX_L;
    assign w_cfg_empty = (cfg_grid_len == '0) || (cfg_batch == '0);
    assign w_busy      = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign w_err_in    = err_unalligned_data || err_user_flag;
    assign w_hs        = (r_state == S_STREAM) && r_tvalid && m_axis_grid_tready;
    assign w_s_inc     = r_s + ONE_B;
    assign w_final_hs  = w_hs && r_tlast && (w_s_inc == r_batch);
    assign w_rslt      = w_busy && mon_rslt_tvalid && mon_rslt_tready && mon_rslt_tlast;
    assign w_r_next    = r_r + (w_rslt ? ONE_B : '0);
    assign w_pt_inc    = r_pt + ONE_L;

    // Table is writable only while idle so a running batch sees a frozen table.
    always_ff @(posedge clk) begin
        if (cfg_wr_en && (r_state == S_IDLE))
            r_grid[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_cfg_bad)        w_state_next = S_ABORT;
                    else if (w_cfg_empty) w_state_next = S_DONE;
                    else                  w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                // Error wins over a simultaneous final handshake.
                if (w_err_in)        w_state_next = S_ABORT;
                else if (w_final_hs) w_state_next = (w_r_next >= r_batch) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_err_in)              w_state_next = S_ABORT;
                else if (r_r >= r_batch)   w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            S_ABORT: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len    <= '0;
            r_pt     <= '0;
            r_batch  <= '0;
            r_s      <= '0;
            r_r      <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_error  <= 1'b0;
        end else if (w_start) begin
            r_len    <= cfg_grid_len;
            r_batch  <= cfg_batch;
            r_pt     <= '0;
            r_s      <= '0;
            r_r      <= '0;
            r_error  <= w_cfg_bad;
            r_tvalid <= !w_cfg_bad && !w_cfg_empty;
            r_tlast  <= (cfg_grid_len == ONE_L);
            r_tdata  <= r_grid[0];
        end else begin
            r_r <= w_r_next;
            if (w_state_next == S_ABORT) begin
                // Processor self-resets on error, so the valid is dropped without a handshake.
                r_error  <= 1'b1;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end else if (w_hs) begin
                if (r_tlast) begin
                    r_s <= w_s_inc;
                    if (w_final_hs) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                    end else begin
                        r_pt    <= '0;
                        r_tdata <= r_grid[0];
                        r_tlast <= (r_len == ONE_L);
                    end
                end else begin
                    r_pt    <= w_pt_inc;
                    r_tdata <= r_grid[w_pt_inc[ADDR_WIDTH-1:0]];
                    r_tlast <= (w_pt_inc == (r_len - ONE_L));
                end
            end
        end
    end

    assign busy               = w_busy;
    assign done               = (r_state == S_DONE);
    assign error              = r_error;
    assign m_axis_grid_tdata  = r_tdata;
    assign m_axis_grid_tvalid = r_tvalid;
    assign m_axis_grid_tlast  = r_tlast;

endmodule
